// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//   Bundles the functional-unit result handshake and the common-data-bus
//   broadcast lanes of the CDB arbiter.
//
//   Handshake: a result moves from FU i into the arbiter on a rising clk
//   edge where fu_valid[i] and fu_ready[i] are both high. fu_ready never
//   depends on fu_valid. A lane of the CDB carries a result for exactly one
//   cycle when cdb_valid[k] is high. The CDB has no back-pressure.
//
//   Signals
//     fu_valid      [NUM_FU]            FU i offers a completed result
//     fu_rob_index  [NUM_FU*IDX_W]      ROB index of FU i, slice [i*IDX_W +: IDX_W]
//     fu_result     [NUM_FU*DATA_W]     result of FU i, slice [i*DATA_W +: DATA_W]
//     fu_ready      [NUM_FU]            arbiter takes FU i's result this cycle
//     cdb_valid     [NUM_LANES]         lane k broadcasts this cycle
//     cdb_rob_index [NUM_LANES*IDX_W]   ROB index on lane k
//     cdb_result    [NUM_LANES*DATA_W]  result on lane k
//     pending_count [3]                 occupied holding slots
//
//   Modports: master = the FU/ROB side, slave = the arbiter.
interface cdb_arbiter_if #(
   parameter int NUM_FU    = 6,
   parameter int NUM_LANES = 4,
   parameter int IDX_W     = 4,
   parameter int DATA_W    = 16
) ();
   logic [NUM_FU-1:0]           fu_valid;
   logic [NUM_FU*IDX_W-1:0]     fu_rob_index;
   logic [NUM_FU*DATA_W-1:0]    fu_result;
   logic [NUM_FU-1:0]           fu_ready;
   logic [NUM_LANES-1:0]        cdb_valid;
   logic [NUM_LANES*IDX_W-1:0]  cdb_rob_index;
   logic [NUM_LANES*DATA_W-1:0] cdb_result;
   logic [2:0]                  pending_count;

   modport master (
      output fu_valid, fu_rob_index, fu_result,
      input  fu_ready, cdb_valid, cdb_rob_index, cdb_result, pending_count
   );

   modport slave (
      input  fu_valid, fu_rob_index, fu_result,
      output fu_ready, cdb_valid, cdb_rob_index, cdb_result, pending_count
   );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Collects completed results from NUM_FU functional units into one holding
//   slot per FU and broadcasts up to NUM_LANES of them per cycle on the
//   common data bus. Slots are served round-robin starting at rr_ptr; the
//   granted slots fill lanes 0.. in scan order with no gaps. Broadcasts are
//   registered, so a result accepted at edge E is on the CDB after edge E+1
//   at the earliest.
//
//   Ports
//     clk    clock, all state changes on the rising edge
//     rst_n  synchronous active-low reset (highest priority)
//     flush  discards every held and in-flight result; rr_ptr is kept
//     bus    cdb_arbiter_if.slave: FU handshake, CDB lanes, pending_count
module cdb_arbiter #(
   parameter int NUM_FU    = 6,
   parameter int NUM_LANES = 4,
   parameter int IDX_W     = 4,
   parameter int DATA_W    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   cdb_arbiter_if.slave  bus
);
   localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   // Holding slots
   logic [NUM_FU-1:0] hold_valid;
   logic [IDX_W-1:0]  hold_idx  [NUM_FU];
   logic [DATA_W-1:0] hold_data [NUM_FU];
   logic [PTR_W-1:0]  rr_ptr;

   // Arbitration results
   logic [NUM_FU-1:0]    grant;
   logic [PTR_W-1:0]     rr_ptr_nxt;
   logic [NUM_LANES-1:0] lane_vld;
   logic [IDX_W-1:0]     lane_idx  [NUM_LANES];
   logic [DATA_W-1:0]    lane_data [NUM_LANES];
   logic [PTR_W:0]       scan_sum;
   logic [PTR_W-1:0]     scan_slot;
   logic [LANE_W:0]      lane_cnt;

   // Handshake
   logic [NUM_FU-1:0] fu_ready;
   logic [NUM_FU-1:0] take;

   // Registered CDB
   logic [NUM_LANES-1:0]        cdb_valid_q;
   logic [NUM_LANES*IDX_W-1:0]  cdb_idx_q;
   logic [NUM_LANES*DATA_W-1:0] cdb_data_q;
   logic [PTR_W:0]              pend_cnt;

   // Walk the slots once starting at rr_ptr; the first NUM_LANES occupied
   // ones win and are packed into lanes in the order they are met. The
   // pointer moves to just past the last winner so skipped slots lead next
   // time.
   always_comb begin : arbitrate
      grant      = '0;
      lane_vld   = '0;
      rr_ptr_nxt = rr_ptr;
      scan_sum   = '0;
      scan_slot  = '0;
      lane_cnt   = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         lane_idx[k]  = '0;
         lane_data[k] = '0;
      end
      for (int j = 0; j < NUM_FU; j++) begin
         scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(j);
         if (scan_sum >= (PTR_W+1)'(NUM_FU)) begin
            scan_sum = scan_sum - (PTR_W+1)'(NUM_FU);
         end
         scan_slot = scan_sum[PTR_W-1:0];
         if (hold_valid[scan_slot] && (lane_cnt < (LANE_W+1)'(NUM_LANES))) begin
            grant[scan_slot]                  = 1'b1;
            lane_vld[lane_cnt[LANE_W-1:0]]  = 1'b1;
            lane_idx[lane_cnt[LANE_W-1:0]]  = hold_idx[scan_slot];
            lane_data[lane_cnt[LANE_W-1:0]] = hold_data[scan_slot];
            lane_cnt                          = lane_cnt + 1'b1;
            rr_ptr_nxt = (scan_slot == PTR_W'(NUM_FU - 1)) ? '0 : scan_slot + 1'b1;
         end
      end
   end

   // A slot being broadcast this cycle is free again at the edge, so it may
   // accept a new result at the same edge.
   assign fu_ready = {NUM_FU{rst_n & ~flush}} & (~hold_valid | grant);
   assign take     = bus.fu_valid & fu_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_valid  <= '0;
         rr_ptr      <= '0;
         cdb_valid_q <= '0;
         cdb_idx_q   <= '0;
         cdb_data_q  <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            hold_idx[i]  <= '0;
            hold_data[i] <= '0;
         end
      end else if (flush) begin
         hold_valid  <= '0;
         cdb_valid_q <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (take[i]) begin
               hold_valid[i] <= 1'b1;
               hold_idx[i]   <= bus.fu_rob_index[i*IDX_W +: IDX_W];
               hold_data[i]  <= bus.fu_result[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
               hold_valid[i] <= 1'b0;
            end
         end
         rr_ptr      <= rr_ptr_nxt;
         cdb_valid_q <= lane_vld;
         for (int k = 0; k < NUM_LANES; k++) begin
            cdb_idx_q[k*IDX_W +: IDX_W]    <= lane_idx[k];
            cdb_data_q[k*DATA_W +: DATA_W] <= lane_data[k];
         end
      end
   end

   always_comb begin : count_pending
      pend_cnt = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         pend_cnt = pend_cnt + {{PTR_W{1'b0}}, hold_valid[i]};
      end
   end

   assign bus.fu_ready      = fu_ready;
   assign bus.cdb_valid     = cdb_valid_q;
   assign bus.cdb_rob_index = cdb_idx_q;
   assign bus.cdb_result    = cdb_data_q;
   assign bus.pending_count = 3'(pend_cnt);
endmodule
